// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared types and default parameters for the SPI-to-register-file bridge.
//   state_e : bridge FSM states
//   src_e   : which requester owns the access currently in flight
//   *_DEF   : default widths, read latency, address limit and lock-key address
// -----------------------------------------------------------------------------
package spi_reg_pkg;

  localparam int REG_AW_DEF    = 7;
  localparam int REG_DW_DEF    = 8;
  localparam int REG_CRC_W_DEF = 8;
  localparam int RD_LAT_DEF    = 1;

  localparam logic [REG_AW_DEF-1:0] ADDR_MAX_DEF      = 7'h3F;
  localparam logic [REG_AW_DEF-1:0] LOCK_KEY_ADDR_DEF = 7'h3F;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RWAIT,
    ACK,
    COOL
  } state_e;

  typedef enum logic {
    SRC_SPI,
    SRC_INT
  } src_e;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge_if
// Request/ack bundle between the SPI slave and the register bridge.
//   spi_reg_wr_req / spi_reg_rd_req : level requests from the SPI slave
//   spi_reg_addr / _wdata / _wcrc   : access address, write data, write CRC
//   reg_spi_wack / reg_spi_rack     : single-cycle acks from the bridge
//   reg_spi_data / reg_spi_addr     : response data/address, valid with the ack
// Modports: master = SPI slave side, slave = bridge side.
// -----------------------------------------------------------------------------
interface spi_reg_bridge_if
  import spi_reg_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int REG_DW    = REG_DW_DEF,
  parameter int REG_CRC_W = REG_CRC_W_DEF
);

  logic                 spi_reg_wr_req;
  logic                 spi_reg_rd_req;
  logic [REG_AW-1:0]    spi_reg_addr;
  logic [REG_DW-1:0]    spi_reg_wdata;
  logic [REG_CRC_W-1:0] spi_reg_wcrc;
  logic                 reg_spi_wack;
  logic                 reg_spi_rack;
  logic [REG_DW-1:0]    reg_spi_data;
  logic [REG_AW-1:0]    reg_spi_addr;

  modport master (
    output spi_reg_wr_req, spi_reg_rd_req, spi_reg_addr, spi_reg_wdata, spi_reg_wcrc,
    input  reg_spi_wack, reg_spi_rack, reg_spi_data, reg_spi_addr
  );

  modport slave (
    input  spi_reg_wr_req, spi_reg_rd_req, spi_reg_addr, spi_reg_wdata, spi_reg_wcrc,
    output reg_spi_wack, reg_spi_rack, reg_spi_data, reg_spi_addr
  );

endinterface

// File: rtl/rf_rd_pipe.sv
// -----------------------------------------------------------------------------
// rf_rd_pipe
// LAT-deep valid shift line for a register-file read: a token entering on
// i_valid in the strobe cycle leaves on o_valid exactly LAT cycles later,
// which is the cycle in which the register file's read data is valid.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid        : read issued this cycle
//   o_valid        : read data valid this cycle
// -----------------------------------------------------------------------------
module rf_rd_pipe #(
  parameter int LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  output logic o_valid
);

  logic [LAT-1:0] sr;

  generate
    if (LAT == 1) begin : g_one
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sr <= '0;
        else          sr <= i_valid;
      end
    end else begin : g_many
      // NOTE: this shift line is control state, not storage, so it is reset;
      // a token left over from a read cut off by reset must not fire later.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sr <= '0;
        else          sr <= {sr[LAT-2:0], i_valid};
      end
    end
  endgenerate

  assign o_valid = sr[LAT-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
// Bridges level-held SPI slave requests and an internal write requester onto a
// single register-file port, one access at a time, with range and write-lock
// enforcement. Acks are single-cycle pulses; response address/data hold until
// the next SPI ack.
//   i_clk, i_rst_n          : core clock, asynchronous active-low reset
//   spi (slave modport)     : SPI requests in, acks/response out
//   i_int_wr_req/addr/wdata : internal write request (level until o_int_wack)
//   o_int_wack              : internal write ack pulse
//   i_wr_lock               : blocks SPI writes except to LOCK_KEY_ADDR
//   o_rf_wen / o_rf_ren     : register-file write/read strobes (1 cycle)
//   o_rf_addr/wdata/wcrc    : register-file address, write data, write CRC
//   i_rf_rdata              : read data, valid RD_LAT cycles after o_rf_ren
//   o_acc_err               : pulse with the ack of an illegal/blocked access
// Access timeline (T0 = IDLE cycle that samples the request):
//   write: wen at T1, ack at T2;  read: ren at T1, ack at T2+RD_LAT.
// -----------------------------------------------------------------------------
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int                REG_AW        = REG_AW_DEF,
  parameter int                REG_DW        = REG_DW_DEF,
  parameter int                REG_CRC_W     = REG_CRC_W_DEF,
  parameter int                RD_LAT        = RD_LAT_DEF,
  parameter logic [REG_AW-1:0] ADDR_MAX      = ADDR_MAX_DEF,
  parameter logic [REG_AW-1:0] LOCK_KEY_ADDR = LOCK_KEY_ADDR_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,

  spi_reg_bridge_if.slave      spi,

  input  logic                 i_int_wr_req,
  input  logic [REG_AW-1:0]    i_int_addr,
  input  logic [REG_DW-1:0]    i_int_wdata,
  output logic                 o_int_wack,

  input  logic                 i_wr_lock,

  output logic                 o_rf_wen,
  output logic                 o_rf_ren,
  output logic [REG_AW-1:0]    o_rf_addr,
  output logic [REG_DW-1:0]    o_rf_wdata,
  output logic [REG_CRC_W-1:0] o_rf_wcrc,
  input  logic [REG_DW-1:0]    i_rf_rdata,

  output logic                 o_acc_err
);

  state_e            state;
  src_e              src;
  logic              err_q;     // error verdict taken at T0, reported with the ack
  logic              rd_ok_q;   // read was legal, so read data is real
  logic              wack_q;
  logic              rack_q;
  logic [REG_DW-1:0] rsp_data_q;
  logic [REG_AW-1:0] rsp_addr_q;
  logic              rd_hit;

  logic spi_addr_ok;
  logic spi_wr_ok;

  assign spi_addr_ok = (spi.spi_reg_addr <= ADDR_MAX);
  assign spi_wr_ok   = spi_addr_ok &&
                       (!i_wr_lock || (spi.spi_reg_addr == LOCK_KEY_ADDR));

  // A token enters in the RD cycle whether or not the strobe was issued, so an
  // illegal read still waits the full latency and acks on the normal cycle.
  rf_rd_pipe #(
    .LAT (RD_LAT)
  ) u_rd_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (state == RD),
    .o_valid (rd_hit)
  );

  // NOTE: all FSM state and registered outputs use non-blocking assignments so
  // every branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      src        <= SRC_SPI;
      err_q      <= 1'b0;
      rd_ok_q    <= 1'b0;
      wack_q     <= 1'b0;
      rack_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
      o_int_wack <= 1'b0;
      o_rf_wen   <= 1'b0;
      o_rf_ren   <= 1'b0;
      o_rf_addr  <= '0;
      o_rf_wdata <= '0;
      o_rf_wcrc  <= '0;
      o_acc_err  <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle pulses unless re-asserted below.
      o_rf_wen   <= 1'b0;
      o_rf_ren   <= 1'b0;
      wack_q     <= 1'b0;
      rack_q     <= 1'b0;
      o_int_wack <= 1'b0;
      o_acc_err  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (spi.spi_reg_wr_req) begin
            // A simultaneous read is dropped and flagged; the slave re-issues.
            src        <= SRC_SPI;
            o_rf_addr  <= spi.spi_reg_addr;
            o_rf_wdata <= spi.spi_reg_wdata;
            o_rf_wcrc  <= spi.spi_reg_wcrc;
            o_rf_wen   <= spi_wr_ok;
            err_q      <= !spi_wr_ok || spi.spi_reg_rd_req;
            state      <= WR;
          end else if (spi.spi_reg_rd_req) begin
            src        <= SRC_SPI;
            o_rf_addr  <= spi.spi_reg_addr;
            o_rf_ren   <= spi_addr_ok;
            rd_ok_q    <= spi_addr_ok;
            err_q      <= !spi_addr_ok;
            state      <= RD;
          end else if (i_int_wr_req) begin
            // Internal writes bypass range and lock checks and carry no CRC.
            src        <= SRC_INT;
            o_rf_addr  <= i_int_addr;
            o_rf_wdata <= i_int_wdata;
            o_rf_wcrc  <= '0;
            o_rf_wen   <= 1'b1;
            err_q      <= 1'b0;
            state      <= WR;
          end
        end

        WR: begin
          if (src == SRC_SPI) begin
            wack_q     <= 1'b1;
            rsp_addr_q <= o_rf_addr;
            rsp_data_q <= o_rf_wdata;
            o_acc_err  <= err_q;
          end else begin
            o_int_wack <= 1'b1;
          end
          state <= ACK;
        end

        RD: state <= RWAIT;

        RWAIT: begin
          if (rd_hit) begin
            rack_q     <= 1'b1;
            rsp_addr_q <= o_rf_addr;
            rsp_data_q <= rd_ok_q ? i_rf_rdata : '0;
            o_acc_err  <= err_q;
            state      <= ACK;
          end
        end

        // SPI accesses take an extra cycle so the slave's one-cycle-late
        // request deassert is not mistaken for a new request.
        ACK: state <= (src == SRC_SPI) ? COOL : IDLE;

        COOL: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  assign spi.reg_spi_wack = wack_q;
  assign spi.reg_spi_rack = rack_q;
  assign spi.reg_spi_data = rsp_data_q;
  assign spi.reg_spi_addr = rsp_addr_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bridge
// Directed bench for spi_reg_bridge. dut1 uses RD_LAT=1 and carries most of the
// sequence; dut3 uses RD_LAT=3 for the long-latency read. Inputs change and
// outputs are sampled 1 ns after the rising edge. Cycle names Tn follow the
// access timeline with T0 the IDLE cycle that samples the request.
// -----------------------------------------------------------------------------
module tb_spi_reg_bridge;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  spi_reg_bridge_if #(.REG_AW(7), .REG_DW(8), .REG_CRC_W(8)) spi1 ();
  spi_reg_bridge_if #(.REG_AW(7), .REG_DW(8), .REG_CRC_W(8)) spi3 ();

  logic       int_wr_req;
  logic [6:0] int_addr;
  logic [7:0] int_wdata;
  logic       int_wack;
  logic       wr_lock;
  logic       rf_wen;
  logic       rf_ren;
  logic [6:0] rf_addr;
  logic [7:0] rf_wdata;
  logic [7:0] rf_wcrc;
  logic [7:0] rf_rdata;
  logic       acc_err;

  logic       int_wack3;
  logic       rf_wen3;
  logic       rf_ren3;
  logic [6:0] rf_addr3;
  logic [7:0] rf_wdata3;
  logic [7:0] rf_wcrc3;
  logic [7:0] rf_rdata3;
  logic       acc_err3;

  spi_reg_bridge #(.RD_LAT(1)) dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .spi          (spi1),
    .i_int_wr_req (int_wr_req),
    .i_int_addr   (int_addr),
    .i_int_wdata  (int_wdata),
    .o_int_wack   (int_wack),
    .i_wr_lock    (wr_lock),
    .o_rf_wen     (rf_wen),
    .o_rf_ren     (rf_ren),
    .o_rf_addr    (rf_addr),
    .o_rf_wdata   (rf_wdata),
    .o_rf_wcrc    (rf_wcrc),
    .i_rf_rdata   (rf_rdata),
    .o_acc_err    (acc_err)
  );

  spi_reg_bridge #(.RD_LAT(3)) dut3 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .spi          (spi3),
    .i_int_wr_req (1'b0),
    .i_int_addr   (7'h00),
    .i_int_wdata  (8'h00),
    .o_int_wack   (int_wack3),
    .i_wr_lock    (1'b0),
    .o_rf_wen     (rf_wen3),
    .o_rf_ren     (rf_ren3),
    .o_rf_addr    (rf_addr3),
    .o_rf_wdata   (rf_wdata3),
    .o_rf_wcrc    (rf_wcrc3),
    .i_rf_rdata   (rf_rdata3),
    .o_acc_err    (acc_err3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_wen"},   32'(rf_wen), 0);
    check({tag, "_ren"},   32'(rf_ren), 0);
    check({tag, "_wack"},  32'(spi1.reg_spi_wack), 0);
    check({tag, "_rack"},  32'(spi1.reg_spi_rack), 0);
    check({tag, "_rdat"},  32'(spi1.reg_spi_data), 0);
    check({tag, "_radr"},  32'(spi1.reg_spi_addr), 0);
    check({tag, "_iwack"}, 32'(int_wack), 0);
    check({tag, "_err"},   32'(acc_err), 0);
    check({tag, "_raddr"}, 32'(rf_addr), 0);
    check({tag, "_rwdat"}, 32'(rf_wdata), 0);
    check({tag, "_rwcrc"}, 32'(rf_wcrc), 0);
  endtask

  initial begin
    rst_n               = 1'b0;
    spi1.spi_reg_wr_req = 1'b0;
    spi1.spi_reg_rd_req = 1'b0;
    spi1.spi_reg_addr   = 7'h00;
    spi1.spi_reg_wdata  = 8'h00;
    spi1.spi_reg_wcrc   = 8'h00;
    spi3.spi_reg_wr_req = 1'b0;
    spi3.spi_reg_rd_req = 1'b0;
    spi3.spi_reg_addr   = 7'h00;
    spi3.spi_reg_wdata  = 8'h00;
    spi3.spi_reg_wcrc   = 8'h00;
    int_wr_req          = 1'b0;
    int_addr            = 7'h00;
    int_wdata           = 8'h00;
    wr_lock             = 1'b0;
    rf_rdata            = 8'hEE;
    rf_rdata3           = 8'hEE;

    // Reset state
    step(); step();
    check_outs_zero("rst");
    rst_n = 1'b1;
    step(); step();

    // SPI write 0x12 <= 0xA5, crc 0x3C, unlocked
    spi1.spi_reg_wr_req = 1'b1;
    spi1.spi_reg_addr   = 7'h12;
    spi1.spi_reg_wdata  = 8'hA5;
    spi1.spi_reg_wcrc   = 8'h3C;
    step(); // T1
    check("wr_t1_wen",  32'(rf_wen), 1);
    check("wr_t1_addr", 32'(rf_addr), 'h12);
    check("wr_t1_data", 32'(rf_wdata), 'hA5);
    check("wr_t1_crc",  32'(rf_wcrc), 'h3C);
    check("wr_t1_wack", 32'(spi1.reg_spi_wack), 0);
    step(); // T2
    check("wr_t2_wack", 32'(spi1.reg_spi_wack), 1);
    check("wr_t2_wen",  32'(rf_wen), 0);
    check("wr_t2_radr", 32'(spi1.reg_spi_addr), 'h12);
    check("wr_t2_rdat", 32'(spi1.reg_spi_data), 'hA5);
    check("wr_t2_err",  32'(acc_err), 0);
    step(); // T3 COOL, request still held
    check("wr_t3_wack", 32'(spi1.reg_spi_wack), 0);
    check("wr_t3_wen",  32'(rf_wen), 0);
    step(); // T4 IDLE
    spi1.spi_reg_wr_req = 1'b0;
    check("wr_t4_nowen", 32'(rf_wen), 0);
    check("wr_t4_radr",  32'(spi1.reg_spi_addr), 'h12);
    step();

    // SPI read 0x05, RD_LAT=1; rdata only valid at T2
    spi1.spi_reg_rd_req = 1'b1;
    spi1.spi_reg_addr   = 7'h05;
    step(); // T1
    check("rd1_t1_ren",  32'(rf_ren), 1);
    check("rd1_t1_addr", 32'(rf_addr), 'h05);
    check("rd1_t1_wen",  32'(rf_wen), 0);
    step(); // T2
    check("rd1_t2_rack", 32'(spi1.reg_spi_rack), 0);
    check("rd1_t2_ren",  32'(rf_ren), 0);
    rf_rdata = 8'h7E;
    step(); // T3
    rf_rdata = 8'hEE;
    check("rd1_t3_rack", 32'(spi1.reg_spi_rack), 1);
    check("rd1_t3_data", 32'(spi1.reg_spi_data), 'h7E);
    check("rd1_t3_addr", 32'(spi1.reg_spi_addr), 'h05);
    check("rd1_t3_err",  32'(acc_err), 0);
    step(); // T4 COOL
    check("rd1_t4_rack", 32'(spi1.reg_spi_rack), 0);
    step(); // T5
    spi1.spi_reg_rd_req = 1'b0;
    check("rd1_t5_ren",  32'(rf_ren), 0);
    check("rd1_t5_data", 32'(spi1.reg_spi_data), 'h7E);
    step();

    // SPI read 0x05 on the RD_LAT=3 instance; rdata only valid at T4
    spi3.spi_reg_rd_req = 1'b1;
    spi3.spi_reg_addr   = 7'h05;
    step(); // T1
    check("rd3_t1_ren",  32'(rf_ren3), 1);
    step(); // T2
    check("rd3_t2_rack", 32'(spi3.reg_spi_rack), 0);
    step(); // T3
    check("rd3_t3_rack", 32'(spi3.reg_spi_rack), 0);
    step(); // T4
    check("rd3_t4_rack", 32'(spi3.reg_spi_rack), 0);
    rf_rdata3 = 8'h7E;
    step(); // T5
    rf_rdata3 = 8'hEE;
    check("rd3_t5_rack", 32'(spi3.reg_spi_rack), 1);
    check("rd3_t5_data", 32'(spi3.reg_spi_data), 'h7E);
    check("rd3_t5_addr", 32'(spi3.reg_spi_addr), 'h05);
    step(); // T6 COOL
    check("rd3_t6_rack", 32'(spi3.reg_spi_rack), 0);
    step(); // T7
    spi3.spi_reg_rd_req = 1'b0;
    step();

    // Illegal SPI read 0x50
    spi1.spi_reg_rd_req = 1'b1;
    spi1.spi_reg_addr   = 7'h50;
    step(); // T1
    check("ill_t1_ren",  32'(rf_ren), 0);
    check("ill_t1_err",  32'(acc_err), 0);
    step(); // T2
    check("ill_t2_rack", 32'(spi1.reg_spi_rack), 0);
    step(); // T3
    check("ill_t3_rack", 32'(spi1.reg_spi_rack), 1);
    check("ill_t3_data", 32'(spi1.reg_spi_data), 'h00);
    check("ill_t3_addr", 32'(spi1.reg_spi_addr), 'h50);
    check("ill_t3_err",  32'(acc_err), 1);
    step(); // T4
    check("ill_t4_err",  32'(acc_err), 0);
    step(); // T5
    spi1.spi_reg_rd_req = 1'b0;
    step();

    // Locked write to 0x10 is blocked
    wr_lock             = 1'b1;
    spi1.spi_reg_wr_req = 1'b1;
    spi1.spi_reg_addr   = 7'h10;
    spi1.spi_reg_wdata  = 8'h11;
    spi1.spi_reg_wcrc   = 8'h22;
    step(); // T1
    check("lk_t1_wen",  32'(rf_wen), 0);
    step(); // T2
    check("lk_t2_wack", 32'(spi1.reg_spi_wack), 1);
    check("lk_t2_err",  32'(acc_err), 1);
    check("lk_t2_radr", 32'(spi1.reg_spi_addr), 'h10);
    check("lk_t2_rdat", 32'(spi1.reg_spi_data), 'h11);
    step(); // T3
    check("lk_t3_err",  32'(acc_err), 0);
    step(); // T4
    spi1.spi_reg_wr_req = 1'b0;
    step();

    // Locked write to the key address goes through
    spi1.spi_reg_wr_req = 1'b1;
    spi1.spi_reg_addr   = 7'h3F;
    spi1.spi_reg_wdata  = 8'h5A;
    spi1.spi_reg_wcrc   = 8'h01;
    step(); // T1
    check("key_t1_wen",  32'(rf_wen), 1);
    check("key_t1_addr", 32'(rf_addr), 'h3F);
    step(); // T2
    check("key_t2_wack", 32'(spi1.reg_spi_wack), 1);
    check("key_t2_err",  32'(acc_err), 0);
    step(); // T3
    step(); // T4
    spi1.spi_reg_wr_req = 1'b0;
    wr_lock             = 1'b0;
    step();

    // Internal write raised together with an SPI read
    spi1.spi_reg_rd_req = 1'b1;
    spi1.spi_reg_addr   = 7'h05;
    rf_rdata            = 8'h7E;
    int_wr_req          = 1'b1;
    int_addr            = 7'h20;
    int_wdata           = 8'h99;
    step(); // T1
    check("arb_t1_ren",   32'(rf_ren), 1);
    check("arb_t1_wen",   32'(rf_wen), 0);
    step(); // T2
    step(); // T3
    check("arb_t3_rack",  32'(spi1.reg_spi_rack), 1);
    check("arb_t3_data",  32'(spi1.reg_spi_data), 'h7E);
    check("arb_t3_iwack", 32'(int_wack), 0);
    step(); // T4 COOL
    check("arb_t4_wen",   32'(rf_wen), 0);
    step(); // T5 IDLE, SPI request gone
    spi1.spi_reg_rd_req = 1'b0;
    rf_rdata            = 8'hEE;
    check("arb_t5_wen",   32'(rf_wen), 0);
    step(); // T6
    check("int_wen",      32'(rf_wen), 1);
    check("int_addr",     32'(rf_addr), 'h20);
    check("int_data",     32'(rf_wdata), 'h99);
    check("int_crc",      32'(rf_wcrc), 'h00);
    step(); // T7
    check("int_wack",     32'(int_wack), 1);
    check("int_spiwack",  32'(spi1.reg_spi_wack), 0);
    check("int_radr",     32'(spi1.reg_spi_addr), 'h05);
    int_wr_req = 1'b0;
    step(); // T8
    check("int_t8_iwack", 32'(int_wack), 0);
    check("int_t8_wen",   32'(rf_wen), 0);
    step();

    // SPI write and read requested together: write wins, read dropped
    spi1.spi_reg_wr_req = 1'b1;
    spi1.spi_reg_rd_req = 1'b1;
    spi1.spi_reg_addr   = 7'h07;
    spi1.spi_reg_wdata  = 8'h33;
    spi1.spi_reg_wcrc   = 8'h44;
    step(); // T1
    check("col_t1_wen",  32'(rf_wen), 1);
    check("col_t1_ren",  32'(rf_ren), 0);
    check("col_t1_addr", 32'(rf_addr), 'h07);
    step(); // T2
    check("col_t2_wack", 32'(spi1.reg_spi_wack), 1);
    check("col_t2_rack", 32'(spi1.reg_spi_rack), 0);
    check("col_t2_err",  32'(acc_err), 1);
    step(); // T3
    check("col_t3_rack", 32'(spi1.reg_spi_rack), 0);
    step(); // T4
    spi1.spi_reg_wr_req = 1'b0;
    spi1.spi_reg_rd_req = 1'b0;
    step(); // T5
    check("col_t5_ren",  32'(rf_ren), 0);
    check("col_t5_rack", 32'(spi1.reg_spi_rack), 0);

    // Reset asserted in RWAIT of a read
    spi1.spi_reg_rd_req = 1'b1;
    spi1.spi_reg_addr   = 7'h05;
    rf_rdata            = 8'h7E;
    step(); // T1
    check("rr_t1_ren", 32'(rf_ren), 1);
    step(); // T2 RWAIT
    rst_n = 1'b0;
    #1;
    check_outs_zero("rr_async");
    spi1.spi_reg_rd_req = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("rr_post1_rack", 32'(spi1.reg_spi_rack), 0);
    step();
    check("rr_post2_rack", 32'(spi1.reg_spi_rack), 0);
    step();
    check("rr_post3_rack", 32'(spi1.reg_spi_rack), 0);

    // Next access after reset completes normally
    spi1.spi_reg_rd_req = 1'b1;
    spi1.spi_reg_addr   = 7'h05;
    step(); // T1
    check("rr_nx_t1_ren",  32'(rf_ren), 1);
    step(); // T2
    check("rr_nx_t2_rack", 32'(spi1.reg_spi_rack), 0);
    step(); // T3
    check("rr_nx_t3_rack", 32'(spi1.reg_spi_rack), 1);
    check("rr_nx_t3_data", 32'(spi1.reg_spi_data), 'h7E);
    check("rr_nx_t3_addr", 32'(spi1.reg_spi_addr), 'h05);
    step(); // T4
    step(); // T5
    spi1.spi_reg_rd_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
